// File: rtl/modulation_pkg.sv
// Shared types and constants for the modulation sample feeder.
package modulation_pkg;

    localparam int unsigned MOD_RAM_LATENCY  = 2;
    localparam int unsigned MOD_SAMPLE_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        ISSUE,
        BUSY
    } mod_state_e;

endpackage

// File: rtl/modulation_tick_gen.sv
// Sample-rate divider: one-cycle tick every FREQ_DIV clocks while EN is high.
module modulation_tick_gen
    import modulation_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 EN,
    input  logic [DIV_WIDTH-1:0] FREQ_DIV,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] div_cnt;
    logic [DIV_WIDTH-1:0] div_lim;

    // A divide ratio of zero behaves like one: a tick every cycle.
    assign div_lim = (FREQ_DIV == '0) ? '0 : FREQ_DIV - DIV_WIDTH'(1);
    assign tick    = EN && (div_cnt >= div_lim);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_cnt <= '0;
        end else if (!EN || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/modulation_sampler.sv
// Fetches modulation samples from the buffer RAM on each tick and hands them to the multiplier.
// Optional dropped-tick counter: define MODULATION_SAMPLER_OVERRUN_CNT_EN.
module modulation_sampler
    import modulation_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned DIV_WIDTH  = 32
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        EN,
    input  logic [ADDR_WIDTH-1:0]       CYCLE,
    input  logic [DIV_WIDTH-1:0]        FREQ_DIV,
    output logic [ADDR_WIDTH-1:0]       ADDR,
    input  logic [MOD_SAMPLE_WIDTH-1:0] DATA_IN,
    output logic [MOD_SAMPLE_WIDTH-1:0] M,
    output logic                        START,
    input  logic                        DONE,
    output logic [ADDR_WIDTH-1:0]       IDX,
    output logic [15:0]                 OVERRUN_CNT
);

    mod_state_e            state;
    logic                  tick;
    logic                  pending;
    logic                  fetch;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] ptr_next;

    modulation_tick_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_tick_gen (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .EN       (EN),
        .FREQ_DIV (FREQ_DIV),
        .tick     (tick)
    );

    assign fetch    = (state == IDLE) && EN && (tick || pending);
    // >= rather than == so a CYCLE shrunk below ptr wraps instead of running off.
    assign ptr_next = (ptr >= CYCLE) ? '0 : ptr + ADDR_WIDTH'(1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            ptr     <= '0;
            pending <= 1'b0;
            ADDR    <= '0;
            M       <= '0;
            IDX     <= '0;
            START   <= 1'b0;
        end else begin
            if (!EN) begin
                ptr     <= '0;
                pending <= 1'b0;
            end else if (fetch) begin
                ptr     <= ptr_next;
                pending <= tick && pending;
            end else if (tick && (state != IDLE) && !pending) begin
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (fetch) begin
                        ADDR  <= ptr;
                        state <= RD0;
                    end
                end
                RD0:   state <= (MOD_RAM_LATENCY > 1) ? RD1 : ISSUE;
                RD1:   state <= ISSUE;
                ISSUE: begin
                    M     <= DATA_IN;
                    IDX   <= ADDR;
                    START <= 1'b1;
                    state <= BUSY;
                end
                BUSY: begin
                    START <= 1'b0;
                    if (DONE) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MODULATION_SAMPLER_OVERRUN_CNT_EN
    logic        drop;
    logic [15:0] ovr_cnt;

    // Tick lost: FSM busy and the one-deep queue already holds a tick.
    assign drop = tick && (state != IDLE) && pending;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ovr_cnt <= '0;
        end else if (drop && (ovr_cnt != 16'hFFFF)) begin
            ovr_cnt <= ovr_cnt + 16'd1;
        end
    end

    assign OVERRUN_CNT = ovr_cnt;
`else
    assign OVERRUN_CNT = '0;
`endif

endmodule

// File: tb/tb_modulation_sampler.sv
// Self-checking bench for modulation_sampler: RAM and multiplier models plus a sample scoreboard.
module tb_modulation_sampler;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        EN;
    logic [14:0] CYCLE;
    logic [31:0] FREQ_DIV;
    logic [14:0] ADDR;
    logic [7:0]  DATA_IN = 8'd0;
    logic [7:0]  M;
    logic        START;
    logic        DONE = 1'b0;
    logic [14:0] IDX;
    logic [15:0] OVERRUN_CNT;

    modulation_sampler #(
        .ADDR_WIDTH (15),
        .DIV_WIDTH  (32)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .EN          (EN),
        .CYCLE       (CYCLE),
        .FREQ_DIV    (FREQ_DIV),
        .ADDR        (ADDR),
        .DATA_IN     (DATA_IN),
        .M           (M),
        .START       (START),
        .DONE        (DONE),
        .IDX         (IDX),
        .OVERRUN_CNT (OVERRUN_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  m;
        logic [14:0] idx;
    } exp_t;

    typedef struct {
        int fd;
        int cyc;
        int lat;
        int n;
        int first;
        int spacing;
        int drops;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_start = 0;
    int   lat = 40;
    int   model_ptr = 0;
    int   ovr_exp = 0;
    int   ovr_on;
    int   dcnt = -1;
    int   start_cyc[$];
    exp_t sb_q[$];
    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_seq(input int cyc_v, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.idx = 15'(model_ptr);
            e.m   = 8'(model_ptr + 1);
            sb_q.push_back(e);
            model_ptr = (model_ptr >= cyc_v) ? 0 : model_ptr + 1;
        end
    endtask

    task automatic wait_starts(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK);
            #1;
            if (n_start >= target) break;
        end
        chk("starts_reached", n_start, target);
    endtask

    task automatic end_vec(input int target);
        repeat (lat + 10) @(posedge CLK);
        #1;
        chk("start_count", n_start, target);
        chk("sb_leftover", sb_q.size(), 0);
        chk("overrun", int'(OVERRUN_CNT), ovr_on ? ovr_exp : 0);
    endtask

    always @(posedge CLK) cyc++;

    // Two-stage RAM read pipeline; RAM[i] = i+1.
    logic [7:0] ram_s1 = 8'd0;
    always @(posedge CLK) begin
        ram_s1  <= 8'(ADDR + 15'd1);
        DATA_IN <= ram_s1;
    end

    // Multiplier: DONE is sampled on the lat-th edge after the one that raised START.
    always @(posedge CLK) begin
        #1;
        DONE = 1'b0;
        if (!RST_N) begin
            dcnt = -1;
        end else if (START) begin
            dcnt = lat - 1;
        end else if (dcnt > 0) begin
            dcnt--;
        end
        if (dcnt == 0) begin
            DONE = 1'b1;
            dcnt = -1;
        end
    end

    always @(negedge CLK) begin
        exp_t e;
        if (RST_N && START) begin
            chk("start_done_overlap", int'(DONE), 0);
            start_cyc.push_back(cyc);
            n_start++;
            if (sb_q.size() == 0) begin
                chk("unexpected_start", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("m", int'(M), int'(e.m));
                chk("idx", int'(IDX), int'(e.idx));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b;
        int en_cyc;
`ifdef MODULATION_SAMPLER_OVERRUN_CNT_EN
        ovr_on = 1;
`else
        ovr_on = 0;
`endif
        //            fd  cyc lat n  first spacing drops
        vecs[0] = '{10, 3, 40, 6, 13, 44, 16};
        vecs[1] = '{10, 3, 3,  6, 13, 10, 0};
        vecs[2] = '{0,  7, 40, 4, 4,  44, 131};
        vecs[3] = '{1,  2, 2,  5, 4,  6,  22};
        vecs[4] = '{6,  4, 3,  5, 9,  7,  0};

        RST_N    = 1'b0;
        EN       = 1'b0;
        CYCLE    = 15'd0;
        FREQ_DIV = 32'd0;
        #2;
        chk("rst_addr", int'(ADDR), 0);
        chk("rst_m", int'(M), 0);
        chk("rst_idx", int'(IDX), 0);
        chk("rst_start", int'(START), 0);
        chk("rst_overrun", int'(OVERRUN_CNT), 0);
        #10;
        RST_N = 1'b1;
        repeat (2) @(posedge CLK);

        for (int v = 0; v < 5; v++) begin
            @(posedge CLK);
            #1;
            FREQ_DIV  = 32'(vecs[v].fd);
            CYCLE     = 15'(vecs[v].cyc);
            lat       = vecs[v].lat;
            model_ptr = 0;
            push_seq(vecs[v].cyc, vecs[v].n);
            b      = n_start;
            en_cyc = cyc;
            EN     = 1'b1;
            wait_starts(b + vecs[v].n, vecs[v].first + vecs[v].n * (vecs[v].spacing + 4) + 20);
            EN = 1'b0;
            if (start_cyc.size() >= b + vecs[v].n) begin
                chk("first_start", start_cyc[b] - en_cyc, vecs[v].first);
                for (int k = 1; k < vecs[v].n; k++)
                    chk("spacing", start_cyc[b+k] - start_cyc[b+k-1], vecs[v].spacing);
            end
            ovr_exp += vecs[v].drops;
            end_vec(b + vecs[v].n);
        end

        // Reset asserted while the FSM sits in RD1; M and IDX hold 5 and 4 from the last vector.
        @(posedge CLK);
        #1;
        FREQ_DIV = 32'd0;
        CYCLE    = 15'd7;
        lat      = 40;
        EN       = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_addr", int'(ADDR), 0);
        chk("arst_m", int'(M), 0);
        chk("arst_idx", int'(IDX), 0);
        chk("arst_start", int'(START), 0);
        chk("arst_overrun", int'(OVERRUN_CNT), 0);
        ovr_exp   = 0;
        model_ptr = 0;
        push_seq(7, 1);
        @(posedge CLK);
        #3;
        RST_N  = 1'b1;
        b      = n_start;
        en_cyc = cyc;
        wait_starts(b + 1, 40);
        EN = 1'b0;
        if (start_cyc.size() > b) chk("rst_first_start", start_cyc[b] - en_cyc, 4);
        ovr_exp += 2;
        end_vec(b + 1);

        // CYCLE shrinks from 100 to 5 once ptr has reached 50.
        @(posedge CLK);
        #1;
        FREQ_DIV  = 32'd1;
        CYCLE     = 15'd100;
        lat       = 2;
        model_ptr = 0;
        push_seq(100, 50);
        b  = n_start;
        EN = 1'b1;
        wait_starts(b + 50, 600);
        CYCLE = 15'd5;
        push_seq(5, 8);
        wait_starts(b + 58, 200);
        EN = 1'b0;
        ovr_exp += 2 + 5 * 57;
        end_vec(b + 58);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
